// File: rtl/apb_pkg.sv
// Shared types and defaults for the arbitrated APB master.
// Imported by the arbiter, the handshake interface and the top.
package apb_pkg;

  localparam int APB_AW      = 5;
  localparam int APB_DW      = 32;
  localparam int APB_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_arb_master_if.sv
// Request/grant handshake between the APB master FSM and its arbiter.
// The master presents valids and a take strobe; the arbiter returns the grant.
interface apb_arb_master_if;

  logic [1:0] valid;
  logic       take;
  logic       gnt_vld;
  logic       gnt_id;

  modport master (
    output valid,
    output take,
    input  gnt_vld,
    input  gnt_id
  );

  modport slave (
    input  valid,
    input  take,
    output gnt_vld,
    output gnt_id
  );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter; ptr_q names the requester favoured on a tie.
// The pointer only moves when the master takes the grant.
module apb_rr_arbiter (
  input  logic           clk,
  input  logic           rst_n,
  apb_arb_master_if.slave arb
);

  logic ptr_q;
  logic ptr_d;

  assign arb.gnt_vld = |arb.valid;
  assign arb.gnt_id  = (&arb.valid) ? ptr_q : arb.valid[1];

  // Favour the loser of the grant just taken.
  assign ptr_d = arb.take ? ~arb.gnt_id : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by two requesters through a round-robin arbiter.
// One transfer in flight; wait-state timeout aborts with an error response.
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int AW      = APB_AW,
  parameter int DW      = APB_DW,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          req0_valid,
  input  logic          req0_write,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          resp0_valid,
  output logic [DW-1:0] resp0_rdata,
  output logic          resp0_err,
  input  logic          req1_valid,
  input  logic          req1_write,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          resp1_valid,
  output logic [DW-1:0] resp1_rdata,
  output logic          resp1_err,
  output logic          PSELx,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [DW-1:0] PWDATA,
  input  logic          PREADY,
  input  logic [DW-1:0] PRDATA,
  input  logic          PSLVERR
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  apb_state_e    state_q;
  logic          psel_q;
  logic          penable_q;
  logic          pwrite_q;
  logic [AW-1:0] paddr_q;
  logic [DW-1:0] pwdata_q;
  logic          owner_q;
  logic [7:0]    wait_q;
  logic [1:0]    rvld_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;

  logic          idle;
  logic          grant;
  logic          gid;
  logic          sel_write;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  apb_arb_master_if u_arb_if ();

  apb_rr_arbiter u_arb (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .arb   (u_arb_if)
  );

  // Reset gates idle so ready stays low while PRESETn is asserted.
  assign idle  = PRESETn && (state_q == ST_IDLE);
  assign grant = idle && u_arb_if.gnt_vld;
  assign gid   = u_arb_if.gnt_id;

  assign u_arb_if.valid = {req1_valid, req0_valid};
  assign u_arb_if.take  = grant;

  assign req0_ready = grant && !gid;
  assign req1_ready = grant && gid;

  assign sel_write = gid ? req1_write : req0_write;
  assign sel_addr  = gid ? req1_addr  : req0_addr;
  assign sel_wdata = gid ? req1_wdata : req0_wdata;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      owner_q   <= 1'b0;
      wait_q    <= 8'd0;
      rvld_q    <= 2'b00;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      rvld_q <= 2'b00;
      unique case (state_q)
        ST_IDLE: begin
          if (grant) begin
            state_q   <= ST_SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            pwrite_q  <= sel_write;
            paddr_q   <= sel_addr;
            pwdata_q  <= sel_wdata;
            owner_q   <= gid;
            wait_q    <= 8'd0;
          end
        end
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            state_q         <= ST_IDLE;
            psel_q          <= 1'b0;
            penable_q       <= 1'b0;
            rvld_q[owner_q] <= 1'b1;
            rdata_q         <= pwrite_q ? '0 : PRDATA;
            err_q           <= PSLVERR;
          end else if (wait_q == TO_LIMIT) begin
            state_q         <= ST_IDLE;
            psel_q          <= 1'b0;
            penable_q       <= 1'b0;
            rvld_q[owner_q] <= 1'b1;
            rdata_q         <= '0;
            err_q           <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign PSELx   = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

  assign resp0_valid = rvld_q[0];
  assign resp1_valid = rvld_q[1];
  assign resp0_rdata = rvld_q[0] ? rdata_q : '0;
  assign resp1_rdata = rvld_q[1] ? rdata_q : '0;
  assign resp0_err   = rvld_q[0] & err_q;
  assign resp1_err   = rvld_q[1] & err_q;

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 SHALL have parameter AW, default 5, APB address width.
REQ-002 SHALL have parameter DW, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum ACCESS wait cycles before abort (1..255).
REQ-004 SHALL have port PCLK  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port PRESETn  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have ports reqN_valid  in  1  requester N (N=0,1) has a transfer pending.
REQ-007 SHALL have ports reqN_write  in  1  1=write, 0=read.
REQ-008 SHALL have ports reqN_addr  in  AW  transfer address.
REQ-009 SHALL have ports reqN_wdata  in  DW  write data.
REQ-010 SHALL have ports reqN_ready  out  1  request accepted this cycle.
REQ-011 SHALL have ports respN_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have ports respN_rdata  out  DW  read data; 0 for writes or aborts.
REQ-013 SHALL have ports respN_err  out  1  slave error or timeout.
REQ-014 SHALL have APB ports PSELx out 1, PENABLE out 1, PWRITE out 1, PADDR out AW, PWDATA out DW, PREADY in 1, PRDATA in DW, PSLVERR in 1.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS; IDLE->SETUP on grant; SETUP->ACCESS unconditionally; ACCESS->IDLE on PREADY=1 or timeout; ACCESS->ACCESS otherwise.
REQ-016 SHALL, in IDLE only, assert reqN_ready combinationally for exactly one granted requester with reqN_valid=1; reqN_ready=0 in all other states.
REQ-017 SHALL grant round-robin: single valid wins; both valid -> requester not granted last; after reset requester 0 has priority.
REQ-018 SHALL update the round-robin pointer only on a grant edge.
REQ-019 SHALL latch addr, wdata, write and requester id at the grant edge; APB outputs held stable from SETUP through end of ACCESS.
REQ-020 SHALL drive PSELx=1,PENABLE=0 in SETUP; PSELx=1,PENABLE=1 in ACCESS; PSELx=PENABLE=0 in IDLE.
REQ-021 SHALL count ACCESS cycles with PREADY=0 in an 8-bit wait counter, cleared on SETUP entry.
REQ-022 SHALL, when PREADY=1 in ACCESS, register a completion: respN_valid=1 for the owner on the next cycle, rdata=PRDATA for reads else 0, err=PSLVERR.
REQ-023 SHALL, when the wait counter equals TIMEOUT with PREADY=0, abort: return to IDLE, respN_valid=1, respN_err=1, respN_rdata=0.
REQ-024 SHALL give minimum latency: grant at edge t -> SETUP cycle t+1 -> ACCESS t+2 -> response pulse t+3; next grant possible in cycle t+3.
REQ-025 SHALL never assert resp0_valid and resp1_valid together; responses keep issue order.
REQ-026 SHALL ignore PREADY, PRDATA, PSLVERR outside ACCESS.

Reset
REQ-027 SHALL on PRESETn=0 immediately force FSM=IDLE, all APB outputs 0, reqN_ready=0, respN_valid/rdata/err=0, wait counter 0, pointer favouring requester 0.
REQ-028 SHALL drop an in-flight transfer on reset with no response issued.

Structure
REQ-029 SHALL take the FSM state enum and AW/DW/TIMEOUT defaults from shared package apb_pkg.
REQ-030 SHALL instantiate one sub-module apb_rr_arbiter (2-way round-robin, grant plus pointer).

Verification
REQ-031 Bench SHALL check: req0 write addr 5 data 0xDEADBEEF, slave zero-wait -> SETUP/ACCESS in consecutive cycles, resp0_valid one cycle later, err=0.
REQ-032 Bench SHALL check: req1 read addr 5 after REQ-031 -> resp1_rdata=0xDEADBEEF.
REQ-033 Bench SHALL check: both valid continuously, 4 transfers -> grants 0,1,0,1.
REQ-034 Bench SHALL check: PREADY held low 3 ACCESS cycles -> response at 4th ACCESS+1, APB signals stable throughout.
REQ-035 Bench SHALL check: PREADY never high, TIMEOUT=15 -> abort after 15 waits, respN_err=1, rdata=0, PSELx=0.
REQ-036 Bench SHALL check: PRESETn low during ACCESS -> all outputs 0 same cycle, no response, next grant to requester 0.
